// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch controller for the instruction ROM.
// It runs an IDLE -> RUN -> HALT state machine with a Start handshake.
// In RUN the counter steps by one each cycle. It also takes absolute jumps
// and signed relative branches from the decoder.
// Optional feature macro: FETCH_PERF_CNT_EN. When it is defined, the CycleCnt
// port counts issued instructions and saturates at 16'hFFFF.
module fetch_sequencer #(
  parameter int D    = 12,
  parameter int OFFW = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [D-1:0]    StartAddr,
  input  logic            Stall,
  input  logic            Jump,
  input  logic [D-1:0]    JumpAddr,
  input  logic            Branch,
  input  logic [OFFW-1:0] BrOffset,
  input  logic            HaltReq,
  output logic [D-1:0]    PrgCtr,
  output logic            InstValid,
  output logic            Busy,
`ifdef FETCH_PERF_CNT_EN
  output logic            Done,
  output logic [15:0]     CycleCnt
`else
  output logic            Done
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state_q;
  logic [D-1:0]   pc_q;
  logic           busy_q;
  logic           done_q;
  logic [D-1:0]   br_tgt_d;

  // Sign-extend the branch offset to the address width.
  // The addition then wraps modulo 2**D.
  function automatic logic [D-1:0] branch_target(input logic [D-1:0]    pc,
                                                 input logic [OFFW-1:0] off);
    logic signed [D-1:0] off_sext;
    off_sext = D'($signed(off));
    return pc + off_sext;
  endfunction

  // Relative branch target from the current PC.
  always_comb begin
    br_tgt_d = branch_target(pc_q, BrOffset);
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt_q;

  // Issued-instruction counter. It is cleared on reset and on an accepted
  // Start, and it sticks at all-ones.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if ((state_q == IDLE || state_q == HALT) && Start) begin
      cnt_q <= '0;
    end else if (state_q == RUN && !Stall && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CycleCnt = cnt_q;
`endif

  // Fetch state machine. The next PC priority in RUN is:
  // stall, halt, jump, branch, then sequential.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, HALT: begin
          if (Start) begin
            pc_q    <= StartAddr;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!Stall) begin
            if (HaltReq) begin
              state_q <= HALT;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (Jump) begin
              pc_q <= JumpAddr;
            end else if (Branch) begin
              pc_q <= br_tgt_d;
            end else begin
              pc_q <= pc_q + D'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign PrgCtr    = pc_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign InstValid = (state_q == RUN) && !Stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer. It sweeps the reset state,
// sequential fetch, branch and jump, wrap-around, stall and halt, restart and
// mid-run reset, and the optional issued-instruction counter.
module tb_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [11:0] StartAddr;
  logic        Stall;
  logic        Jump;
  logic [11:0] JumpAddr;
  logic        Branch;
  logic [7:0]  BrOffset;
  logic        HaltReq;
  logic [11:0] PrgCtr;
  logic        InstValid;
  logic        Busy;
  logic        Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] CycleCnt;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_sequencer #(.D(12), .OFFW(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .StartAddr (StartAddr),
    .Stall     (Stall),
    .Jump      (Jump),
    .JumpAddr  (JumpAddr),
    .Branch    (Branch),
    .BrOffset  (BrOffset),
    .HaltReq   (HaltReq),
    .PrgCtr    (PrgCtr),
    .InstValid (InstValid),
    .Busy      (Busy),
`ifdef FETCH_PERF_CNT_EN
    .Done      (Done),
    .CycleCnt  (CycleCnt)
`else
    .Done      (Done)
`endif
  );

  always #5 Clk = ~Clk;

  // Advance one rising edge, then settle 1ns past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset the DUT, then issue Start so it is in RUN at addr.
  task automatic start_at(input logic [11:0] addr);
    Reset = 1'b1; tick();
    Reset = 1'b0;
    Start = 1'b1; StartAddr = addr; tick();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; tick();
    checks++;
    if (PrgCtr !== 12'h000) begin failures++; $display("FAIL reset_pc actual=%h expected=000", PrgCtr); end
    checks++;
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", Busy); end
    checks++;
    if (Done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", Done); end
    checks++;
    if (InstValid !== 1'b0) begin failures++; $display("FAIL reset_ivalid actual=%b expected=0", InstValid); end
    Reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [11:0] exp_pc;
    start_at(12'h010);
    exp_pc = 12'h010;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (PrgCtr !== exp_pc) begin failures++; $display("FAIL seq_pc[%0d] actual=%h expected=%h", i, PrgCtr, exp_pc); end
      checks++;
      if (Busy !== 1'b1 || InstValid !== 1'b1) begin
        failures++; $display("FAIL seq_busy_ivalid[%0d] actual=%b%b expected=11", i, Busy, InstValid);
      end
      tick();
      exp_pc = exp_pc + 12'd1;
    end
  endtask

  task automatic test_branch_jump();
    start_at(12'h020);
    Branch = 1'b1; BrOffset = 8'hFC; tick();
    checks++;
    if (PrgCtr !== 12'h01C) begin failures++; $display("FAIL branch_neg actual=%h expected=01C", PrgCtr); end
    Jump = 1'b1; JumpAddr = 12'h300; tick();
    checks++;
    if (PrgCtr !== 12'h300) begin failures++; $display("FAIL jump_over_branch actual=%h expected=300", PrgCtr); end
    Jump = 1'b0; BrOffset = 8'h05; tick();
    checks++;
    if (PrgCtr !== 12'h305) begin failures++; $display("FAIL branch_pos actual=%h expected=305", PrgCtr); end
    Branch = 1'b0;
  endtask

  task automatic test_wrap();
    start_at(12'hFFF);
    tick();
    checks++;
    if (PrgCtr !== 12'h000) begin failures++; $display("FAIL wrap_seq actual=%h expected=000", PrgCtr); end
    tick(); tick();
    checks++;
    if (PrgCtr !== 12'h002) begin failures++; $display("FAIL wrap_pre actual=%h expected=002", PrgCtr); end
    Branch = 1'b1; BrOffset = 8'hF0; tick();
    checks++;
    if (PrgCtr !== 12'hFF2) begin failures++; $display("FAIL wrap_branch_neg actual=%h expected=FF2", PrgCtr); end
    BrOffset = 8'h7F; tick();
    checks++;
    if (PrgCtr !== 12'h071) begin failures++; $display("FAIL wrap_branch_pos actual=%h expected=071", PrgCtr); end
    Branch = 1'b0;
  endtask

  task automatic test_stall_halt();
    start_at(12'h040);
    Stall = 1'b1; Jump = 1'b1; JumpAddr = 12'h123; HaltReq = 1'b1;
    #1;
    checks++;
    if (InstValid !== 1'b0) begin failures++; $display("FAIL stall_ivalid actual=%b expected=0", InstValid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (PrgCtr !== 12'h040 || Busy !== 1'b1 || Done !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] actual pc=%h busy=%b done=%b expected pc=040 busy=1 done=0", i, PrgCtr, Busy, Done);
      end
    end
    Stall = 1'b0;
    #1;
    checks++;
    if (InstValid !== 1'b1) begin failures++; $display("FAIL unstall_ivalid actual=%b expected=1", InstValid); end
    tick();
    checks++;
    if (PrgCtr !== 12'h040 || Busy !== 1'b0 || Done !== 1'b1 || InstValid !== 1'b0) begin
      failures++; $display("FAIL halt_entry actual pc=%h busy=%b done=%b iv=%b expected pc=040 busy=0 done=1 iv=0", PrgCtr, Busy, Done, InstValid);
    end
    HaltReq = 1'b0; Jump = 1'b0;
    tick();
    checks++;
    if (Done !== 1'b0 || PrgCtr !== 12'h040) begin
      failures++; $display("FAIL halt_hold actual done=%b pc=%h expected done=0 pc=040", Done, PrgCtr);
    end
  endtask

  task automatic test_restart_reset();
    Start = 1'b1; StartAddr = 12'h100; tick();
    checks++;
    if (PrgCtr !== 12'h100 || Busy !== 1'b1 || Done !== 1'b0) begin
      failures++; $display("FAIL restart actual pc=%h busy=%b done=%b expected pc=100 busy=1 done=0", PrgCtr, Busy, Done);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (CycleCnt !== 16'd0) begin failures++; $display("FAIL restart_cnt actual=%0d expected=0", CycleCnt); end
`endif
    StartAddr = 12'h555; tick();
    checks++;
    if (PrgCtr !== 12'h101) begin failures++; $display("FAIL start_in_run actual=%h expected=101", PrgCtr); end
    Reset = 1'b1; tick();
    checks++;
    if (PrgCtr !== 12'h000 || Busy !== 1'b0 || InstValid !== 1'b0 || Done !== 1'b0) begin
      failures++; $display("FAIL midrun_reset actual pc=%h busy=%b iv=%b done=%b expected 000 0 0 0", PrgCtr, Busy, InstValid, Done);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (CycleCnt !== 16'd0) begin failures++; $display("FAIL reset_cnt actual=%0d expected=0", CycleCnt); end
`endif
    Reset = 1'b0; Start = 1'b0;
    Jump = 1'b1; JumpAddr = 12'h777; Branch = 1'b1; HaltReq = 1'b1;
    tick();
    checks++;
    if (PrgCtr !== 12'h000 || Busy !== 1'b0) begin
      failures++; $display("FAIL idle_ignore actual pc=%h busy=%b expected pc=000 busy=0", PrgCtr, Busy);
    end
    Jump = 1'b0; Branch = 1'b0; HaltReq = 1'b0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_cnt();
    start_at(12'h200);
    checks++;
    if (CycleCnt !== 16'd0) begin failures++; $display("FAIL cnt_start actual=%0d expected=0", CycleCnt); end
    for (int i = 0; i < 9; i++) tick();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    Stall = 1'b0; HaltReq = 1'b1; tick();
    HaltReq = 1'b0;
    checks++;
    if (CycleCnt !== 16'd10 || Done !== 1'b1) begin
      failures++; $display("FAIL cnt_halt actual cnt=%0d done=%b expected cnt=10 done=1", CycleCnt, Done);
    end
    tick(); tick();
    checks++;
    if (CycleCnt !== 16'd10) begin failures++; $display("FAIL cnt_hold actual=%0d expected=10", CycleCnt); end
    Start = 1'b1; StartAddr = 12'h000; tick();
    Start = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (CycleCnt !== 16'hFFFE) begin failures++; $display("FAIL cnt_fffe actual=%h expected=FFFE", CycleCnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (CycleCnt !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat actual=%h expected=FFFF", CycleCnt); end
  endtask
`endif

  initial begin
    Reset = 1'b1; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
    Jump = 1'b0; JumpAddr = '0; Branch = 1'b0; BrOffset = '0; HaltReq = 1'b0;
    test_reset();
    test_sequential();
    test_branch_jump();
    test_wrap();
    test_stall_halt();
    test_restart_reset();
`ifdef FETCH_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that sequences the 9-bit-wide instruction ROM.
- Drives the ROM address, advances it each cycle, and applies absolute jumps and signed relative branches from the decoder.
- Runs a start/halt handshake with the testbench or top level.
- Sits between the top-level control, the ROM, and the decode/branch logic.

Parameters:
D, 12, ROM address width; PrgCtr range is 0..2**D-1.
OFFW, 8, width of the signed relative branch offset.

Ports:
Clk  in  1  system clock; all state updates on rising edge.
Reset  in  1  synchronous, active-high reset.
Start  in  1  begin execution; sampled in IDLE or HALT only.
StartAddr  in  D  PrgCtr value loaded on an accepted Start.
Stall  in  1  freeze PrgCtr for this cycle (RUN only).
Jump  in  1  absolute jump request for the current instruction.
JumpAddr  in  D  absolute jump target.
Branch  in  1  taken relative branch for the current instruction.
BrOffset  in  OFFW  signed two's-complement offset, added to the current PrgCtr.
HaltReq  in  1  current instruction is a halt (from decoder).
PrgCtr  out  D  registered ROM address.
InstValid  out  1  the ROM output at PrgCtr is a live instruction this cycle.
Busy  out  1  high while in RUN.
Done  out  1  one-cycle pulse on entry to HALT.
CycleCnt  out  16  present only with the optional feature (see below).

Behaviour:
- Reset:
  - Synchronous, active-high; dominates all other inputs in any state, including mid-RUN.
  - Next edge gives state=IDLE, PrgCtr=0, Done=0, Busy=0, InstValid=0.
- States: IDLE, RUN, HALT (2-bit encoded).
- IDLE:
  - Start=1 → PrgCtr<=StartAddr, state<=RUN.
  - Otherwise hold.
  - Jump, Branch, HaltReq and Stall are ignored.
- RUN:
  - Busy=1.
  - InstValid = ~Stall (combinational from state and Stall).
  - Next-PC priority, evaluated each edge:
    1. Stall=1: PrgCtr holds. Jump, Branch and HaltReq are ignored this cycle.
    2. HaltReq=1: PrgCtr holds, state<=HALT, Done<=1 for exactly one cycle.
    3. Jump=1: PrgCtr<=JumpAddr. Jump wins over a simultaneous Branch.
    4. Branch=1: PrgCtr<=PrgCtr + sign-extended BrOffset, computed modulo 2**D.
    5. Else: PrgCtr<=PrgCtr+1.
  - Start is ignored in RUN.
- Wrap-around:
  - PrgCtr=2**D-1 with sequential advance gives 0.
  - A negative branch below 0 wraps modulo 2**D.
  - No fault flag.
- HALT:
  - Busy=0, InstValid=0, PrgCtr holds the halt instruction's address.
  - Done is high only on the first HALT cycle, then 0.
  - Start=1 → PrgCtr<=StartAddr, state<=RUN (re-run without reset).
- Latency:
  - PrgCtr changes one edge after its controlling inputs.
  - The ROM is combinational, so the instruction at the new PrgCtr is valid in that same cycle.
  - Branch/Jump therefore take effect on the next instruction with no bubble.
- Simultaneous Start and Reset: Reset wins.
- All outputs are driven from registers, except InstValid (state AND ~Stall).

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined:
  - CycleCnt port exists: a 16-bit counter of cycles spent in RUN with InstValid=1, i.e. instructions issued.
  - Cleared to 0 by Reset and by an accepted Start.
  - Saturates at 16'hFFFF; no wrap.
  - Holds its value in HALT for readout.
- When undefined:
  - The CycleCnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
1. Reset, then Start=1 with StartAddr=12'h010, no other stimulus for 4 cycles → PrgCtr 010,011,012,013; Busy=1; InstValid=1.
2. In RUN at PrgCtr=12'h020, Branch=1 with BrOffset=8'hFC (-4) → next PrgCtr=12'h01C. Repeat with Jump=1, JumpAddr=12'h300 and Branch=1 together → next PrgCtr=12'h300.
3. PrgCtr=12'hFFF, sequential advance → 12'h000. At PrgCtr=12'h002, BrOffset=8'hF0 (-16) → 12'hFF2.
4. In RUN at 12'h040, Stall=1 for 3 cycles with Jump=1 and HaltReq=1 held → PrgCtr stays 040, InstValid=0, state stays RUN. After Stall drops with HaltReq=1 → HALT, Done pulses once, PrgCtr=040.
5. In HALT, Start=1 with StartAddr=12'h100 → RUN, PrgCtr=100, Done=0. Assert Reset mid-RUN → next edge IDLE, PrgCtr=0, Busy=0. With FETCH_PERF_CNT_EN, CycleCnt=0.
6. With FETCH_PERF_CNT_EN: run 10 unstalled and 3 stalled cycles, then halt → CycleCnt=10, held in HALT. Force the counter to 16'hFFFE and run 5 cycles → CycleCnt=16'hFFFF.
